// File: rtl/fir_err_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_err_pkg
//  Description : Shared types and constants for the FIR error monitor:
//                FSM state encoding, default widths and pipeline depth.
//                Optional feature macro used by the users of this package:
//                FIR_ERR_BIAS_EN (signed bias accumulator).
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_err_pkg;

  // Default width of the exact and approximate FIR outputs
  localparam int c_DATA_W_DEF   = 16;
  // Default log2 of the measurement window length in samples
  localparam int c_WIN_LOG2_DEF = 8;
  // Register stages between an accepted pair and its accumulator update
  localparam int c_PIPE_DEPTH   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage : fir_err_pkg
`default_nettype wire

// File: rtl/fir_abs_diff.sv
`default_nettype none
// ============================================================================
//  Module      : fir_abs_diff
//  Description : Stage 1 of the error monitor pipeline. Registers the
//                absolute difference |approx - exact| of one sample pair
//                together with its valid bit. With FIR_ERR_BIAS_EN defined
//                the signed difference (approx - exact) is registered too.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_abs_diff
  import fir_err_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [DATA_W-1:0]        i_exact,
  input  logic [DATA_W-1:0]        i_approx,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_abs
`ifdef FIR_ERR_BIAS_EN
  ,
  output logic signed [DATA_W:0]   o_diff
`endif
);

  // One extra bit keeps the full range of approx - exact, sign in the MSB
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_abs;

  assign w_diff = {1'b0, i_approx} - {1'b0, i_exact};

  // Magnitude never exceeds 2^DATA_W-1, so the low DATA_W bits of the
  // negated difference are the exact absolute value
  assign w_abs = w_diff[DATA_W] ? (~w_diff[DATA_W-1:0] + 1'b1)
                                : w_diff[DATA_W-1:0];

  // Valid bit follows the accepted-pair strobe every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= i_valid;
    end
  end

  // Data is only captured for accepted pairs; it is ignored when not valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_abs <= '0;
    end else if (i_valid) begin
      o_abs <= w_abs;
    end
  end

`ifdef FIR_ERR_BIAS_EN
  // Signed difference for the bias accumulator, captured alongside o_abs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_diff <= '0;
    end else if (i_valid) begin
      o_diff <= w_diff;
    end
  end
`endif

endmodule : fir_abs_diff
`default_nettype wire

// File: rtl/fir_error_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : fir_error_monitor
//  Description : Compares the exact-adder and approximate-adder FIR outputs
//                over a window of 2^WIN_LOG2 valid samples and reports the
//                error sum, maximum error, count of erroneous samples and
//                the mean error distance (MED).
//                Optional feature macro: FIR_ERR_BIAS_EN adds the signed
//                err_bias output (sum of approx - exact over the window).
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_error_monitor
  import fir_err_pkg::*;
#(
  parameter  int DATA_W   = c_DATA_W_DEF,
  parameter  int WIN_LOG2 = c_WIN_LOG2_DEF,
  localparam int ACC_W    = DATA_W + WIN_LOG2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        exact_in,
  input  logic [DATA_W-1:0]        approx_in,
  output logic                     busy,
  output logic                     done,
  output logic [ACC_W-1:0]         err_sum,
  output logic [DATA_W-1:0]        err_max,
  output logic [WIN_LOG2:0]        err_count,
  output logic [DATA_W-1:0]        med
`ifdef FIR_ERR_BIAS_EN
  ,
  output logic signed [ACC_W:0]    err_bias
`endif
);

  localparam int              CNT_W        = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] c_WIN_LAST  = CNT_W'((1 << WIN_LOG2) - 1);
  // DRAIN is left once this count is reached: the final pair needs
  // c_PIPE_DEPTH edges to reach the accumulators, and DONE is entered on
  // the following edge, three edges after the final accept
  localparam logic [1:0]       c_DRAIN_LAST = 2'(c_PIPE_DEPTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_drain_cnt;
  logic [CNT_W-1:0]   r_smp_cnt;

  logic               w_accept;
  logic               w_clear;
  logic               w_last;

  logic               w_s1_valid;
  logic [DATA_W-1:0]  w_s1_abs;
  logic               w_s1_nz;

  logic [ACC_W-1:0]   r_err_sum;
  logic [DATA_W-1:0]  r_err_max;
  logic [CNT_W-1:0]   r_err_count;

`ifdef FIR_ERR_BIAS_EN
  logic signed [DATA_W:0] w_s1_diff;
  logic signed [ACC_W:0]  r_err_bias;
`endif

  // --------------------------------------------------------------------------
  // Stage 1: registered absolute difference
  // --------------------------------------------------------------------------
  fir_abs_diff #(
    .DATA_W   (DATA_W)
  ) u_abs_diff (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (w_accept),
    .i_exact  (exact_in),
    .i_approx (approx_in),
    .o_valid  (w_s1_valid),
    .o_abs    (w_s1_abs)
`ifdef FIR_ERR_BIAS_EN
    ,
    .o_diff   (w_s1_diff)
`endif
  );

  assign w_s1_nz = |w_s1_abs;
  assign w_last  = w_accept && (r_smp_cnt == c_WIN_LAST);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start is only honoured in IDLE and DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == c_DRAIN_LAST) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = start ? ST_RUN : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Per-state outputs and datapath strobes
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    w_accept = 1'b0;
    w_clear  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clear = start;
      end
      ST_RUN: begin
        busy     = 1'b1;
        w_accept = in_valid;
      end
      ST_DRAIN: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        done    = 1'b1;
        w_clear = start;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Counts cycles spent in DRAIN; held at zero in every other state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain_cnt <= '0;
    end else if (r_state != ST_DRAIN) begin
      r_drain_cnt <= '0;
    end else begin
      r_drain_cnt <= r_drain_cnt + 2'd1;
    end
  end

  // Accepted-sample counter; stall cycles do not advance it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp_cnt <= '0;
    end else if (w_clear) begin
      r_smp_cnt <= '0;
    end else if (w_accept) begin
      r_smp_cnt <= r_smp_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: accumulators (clear on accepted start wins over any update)
  // --------------------------------------------------------------------------

  // Error sum, maximum and count of nonzero errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sum   <= '0;
      r_err_max   <= '0;
      r_err_count <= '0;
    end else if (w_clear) begin
      r_err_sum   <= '0;
      r_err_max   <= '0;
      r_err_count <= '0;
    end else if (w_s1_valid) begin
      r_err_sum   <= r_err_sum + {{WIN_LOG2{1'b0}}, w_s1_abs};
      if (w_s1_abs > r_err_max) begin
        r_err_max <= w_s1_abs;
      end
      r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, w_s1_nz};
    end
  end

`ifdef FIR_ERR_BIAS_EN
  // Signed bias: sign-extended approx - exact summed over the window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_bias <= '0;
    end else if (w_clear) begin
      r_err_bias <= '0;
    end else if (w_s1_valid) begin
      r_err_bias <= r_err_bias + {{WIN_LOG2{w_s1_diff[DATA_W]}}, w_s1_diff};
    end
  end

  assign err_bias = r_err_bias;
`endif

  assign err_sum   = r_err_sum;
  assign err_max   = r_err_max;
  assign err_count = r_err_count;
  // Mean error distance: truncating divide by the window length
  assign med       = r_err_sum[ACC_W-1:WIN_LOG2];

endmodule : fir_error_monitor
`default_nettype wire

// File: tb/tb_fir_error_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_error_monitor
//  Description : Self-checking bench for fir_error_monitor. Stimulus drives
//                randomized and directed windows; a reference model computes
//                the window statistics with plain integer arithmetic and
//                queues them; a monitor pops and compares on every done.
//                Honours FIR_ERR_BIAS_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_error_monitor;

  localparam int DATA_W   = 16;
  localparam int WIN_LOG2 = 8;
  localparam int ACC_W    = DATA_W + WIN_LOG2;
  localparam int N_WIN    = 1 << WIN_LOG2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 in_valid;
  logic [DATA_W-1:0]    exact_in;
  logic [DATA_W-1:0]    approx_in;
  logic                 busy;
  logic                 done;
  logic [ACC_W-1:0]     err_sum;
  logic [DATA_W-1:0]    err_max;
  logic [WIN_LOG2:0]    err_count;
  logic [DATA_W-1:0]    med;
`ifdef FIR_ERR_BIAS_EN
  logic signed [ACC_W:0] err_bias;
`endif

  fir_error_monitor #(
    .DATA_W    (DATA_W),
    .WIN_LOG2  (WIN_LOG2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .exact_in  (exact_in),
    .approx_in (approx_in),
    .busy      (busy),
    .done      (done),
    .err_sum   (err_sum),
    .err_max   (err_max),
    .err_count (err_count),
    .med       (med)
`ifdef FIR_ERR_BIAS_EN
    ,
    .err_bias  (err_bias)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint sum;
    longint mx;
    longint cnt;
    longint bias;
    int     done_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued window result
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_latency", longint'(cyc), longint'(mon_e.done_cyc));
        chk("err_sum", longint'(err_sum), mon_e.sum);
        chk("err_max", longint'(err_max), mon_e.mx);
        chk("err_count", longint'(err_count), mon_e.cnt);
        chk("med", longint'(med), mon_e.sum / N_WIN);
        chk("busy_done", longint'(busy), 0);
`ifdef FIR_ERR_BIAS_EN
        chk("err_bias", longint'(err_bias), mon_e.bias);
`endif
      end
    end
  end

  // Asynchronous reset in the middle of a cycle; outputs must drop at once
  task automatic abort_with_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_err_sum", longint'(err_sum), 0);
    chk("rst_err_max", longint'(err_max), 0);
    chk("rst_err_count", longint'(err_count), 0);
    chk("rst_med", longint'(med), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    in_valid = 1'b0;
    start    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("rst_idle_busy", longint'(busy), 0);
  endtask

  // Drive one window. mode selects the data pattern, stall the idle-cycle
  // pattern (0 none, 1 alternate, 2 random 0..2). abort_at < N_WIN resets
  // the design after that many pairs instead of finishing the window.
  task automatic run_window(input int mode, input int stall, input bit do_start,
                            input bit mid_start, input int abort_at);
    exp_t        e;
    longint      sum  = 0;
    longint      mx   = 0;
    longint      cnt  = 0;
    longint      bias = 0;
    logic [15:0] ev;
    logic [15:0] av;
    int          ns;
    int          d;
    int          ad;
    if (do_start) begin
      @(negedge clk);
      chk("busy_before_start", longint'(busy), 0);
      start    = 1'b1;
      in_valid = 1'b0;
    end
    for (int k = 0; k < N_WIN; k++) begin
      if (k == abort_at) begin
        abort_with_reset();
        return;
      end
      ns = (stall == 1) ? 1 : (stall == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (ns) begin
        @(negedge clk);
        chk("busy_run", longint'(busy), 1);
        start     = 1'b0;
        in_valid  = 1'b0;
        exact_in  = 16'($urandom);
        approx_in = 16'($urandom);
      end
      @(negedge clk);
      chk("busy_run", longint'(busy), 1);
      case (mode)
        0: begin ev = 16'h1234; av = 16'h1234; end
        1: begin ev = 16'h0100; av = 16'h00FD; end
        2: begin
          if (k == 0) begin ev = 16'h0000; av = 16'hFFFF; end
          else begin ev = 16'($urandom); av = ev; end
        end
        3: begin ev = 16'($urandom); av = 16'($urandom); end
        default: begin
          ev = 16'($urandom);
          av = ev + 16'($urandom_range(0, 8)) - 16'd4;
        end
      endcase
      start     = mid_start && (k == 50);
      in_valid  = 1'b1;
      exact_in  = ev;
      approx_in = av;
      d   = int'(av) - int'(ev);
      ad  = (d < 0) ? -d : d;
      sum  += ad;
      bias += d;
      if (ad > mx) mx = ad;
      if (ad != 0) cnt++;
    end
    @(negedge clk);
    e.sum      = sum;
    e.mx       = mx;
    e.cnt      = cnt;
    e.bias     = bias;
    e.done_cyc = cyc + 3;
    exp_q.push_back(e);
    // Garbage during DRAIN must be ignored, start included
    repeat (2) begin
      chk("busy_drain", longint'(busy), 1);
      in_valid  = 1'b1;
      exact_in  = 16'($urandom);
      approx_in = 16'($urandom);
      start     = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("busy_drain", longint'(busy), 1);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("done_timeout", longint'(exp_q.size()), 0);
    @(negedge clk);
  endtask

  // Assert start on the done cycle; accumulators must clear on that edge
  task automatic restart_on_done();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen  = 1'b1;
        start = 1'b1;
      end
    end
    chk("restart_done_seen", longint'(seen), 1);
    @(negedge clk);
    start = 1'b0;
    chk("restart_err_sum", longint'(err_sum), 0);
    chk("restart_err_max", longint'(err_max), 0);
    chk("restart_err_count", longint'(err_count), 0);
    chk("restart_busy", longint'(busy), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    exact_in  = '0;
    approx_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_err_sum", longint'(err_sum), 0);
    chk("reset_err_max", longint'(err_max), 0);
    chk("reset_err_count", longint'(err_count), 0);
    chk("reset_med", longint'(med), 0);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_window(0, 0, 1'b1, 1'b0, N_WIN);  wait_idle();   // identical inputs
    run_window(1, 0, 1'b1, 1'b0, N_WIN);  wait_idle();   // approx = exact - 3
    run_window(2, 0, 1'b1, 1'b0, N_WIN);  wait_idle();   // one full-scale error
    run_window(1, 1, 1'b1, 1'b0, N_WIN);  wait_idle();   // alternate-cycle valid
    run_window(3, 2, 1'b1, 1'b1, N_WIN);  wait_idle();   // random, start mid-RUN
    run_window(4, 0, 1'b1, 1'b0, N_WIN);                 // back-to-back windows
    restart_on_done();
    run_window(3, 0, 1'b0, 1'b0, N_WIN);  wait_idle();
    run_window(3, 0, 1'b1, 1'b0, 100);                   // reset after 100 pairs
    run_window(4, 2, 1'b1, 1'b0, N_WIN);  wait_idle();   // clean window after reset

    repeat (5) @(negedge clk);
    chk("queue_empty", longint'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fir_error_monitor
`default_nettype wire
